// File: rtl/hdlverifier_capture_buffer_ctrl.sv
// hdlverifier_capture_buffer_ctrl
// Capture buffer controller for the 1-bit trigger path. It arms on request,
// records qualified samples into a circular RAM, freezes a pre/post trigger
// window and streams it out oldest-first over valid/ready.
// Optional feature macro: CAPTURE_TIMESTAMP_EN adds trig_timestamp, a
// saturating count of clk_enable cycles from arm to the qualifying trigger.
module hdlverifier_capture_buffer_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pretrigger_depth,
  output logic                  busy,
  output logic                  capture_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]           trig_timestamp
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE_FILL,
    WAIT_TRIG,
    POST,
    READOUT
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [CW-1:0]         post_q;
  logic [CW-1:0]         fill_cnt;
  logic [CW-1:0]         post_cnt;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         accept_cnt;
  logic                  rd_pending;
  logic                  skid_valid;
  logic                  wr_en;
  logic                  trig_hit;
  logic                  pop;
  logic                  last_accept;
  logic                  issue;
  logic [1:0]            occ;
  logic [1:0]            occ_after;

  // Capture-side qualifiers and readout handshake terms
  always_comb begin
    wr_en       = clk_enable && (state == PRE_FILL || state == WAIT_TRIG || state == POST);
    trig_hit    = clk_enable && trigger && (state == WAIT_TRIG);
    pop         = out_valid && out_ready;
    last_accept = pop && (accept_cnt == CW'(DEPTH - 1));
    // Entries held or in flight (output reg, skid, RAM read) after this cycle's pop;
    // a new read is only issued if its data is guaranteed a slot next cycle.
    occ         = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending);
    occ_after   = occ - 2'(pop);
    issue       = (state == READOUT) && !abort && (issue_cnt < CW'(DEPTH)) && (occ_after < 2'd2);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state and status outputs; abort overrides everything
  always_comb begin
    state_n      = state;
    busy         = (state != IDLE);
    capture_done = (state == READOUT);
    out_last     = out_valid && (accept_cnt == CW'(DEPTH - 1));
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      if (arm) state_n = (pretrigger_depth == '0) ? WAIT_TRIG : PRE_FILL;
        PRE_FILL:  if (wr_en && (fill_cnt + 1'b1 == CW'(pre_q))) state_n = WAIT_TRIG;
        WAIT_TRIG: if (trig_hit) state_n = (post_q == CW'(1)) ? READOUT : POST;
        POST:      if (wr_en && (post_cnt + 1'b1 == post_q)) state_n = READOUT;
        READOUT:   if (last_accept) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Sample buffer: write port for capture, registered read port for readout
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_d;
    if (issue) ram_q <= mem[rd_ptr];
  end

  // Capture counters, window pointers and readout output/skid pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      rd_pending <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (clk_enable) data_d <= data_in;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      if (!abort) begin
        case (state)
          IDLE: if (arm) begin
            // Input width already caps the pre-trigger depth at DEPTH-1.
            pre_q    <= pretrigger_depth;
            post_q   <= CW'(DEPTH) - CW'(pretrigger_depth);
            fill_cnt <= '0;
          end
          PRE_FILL:  if (wr_en) fill_cnt <= fill_cnt + 1'b1;
          WAIT_TRIG: if (trig_hit) begin
            // Oldest window sample sits pre entries behind the trigger write.
            rd_ptr   <= wr_ptr - pre_q;
            post_cnt <= CW'(1);
          end
          POST:      if (wr_en) post_cnt <= post_cnt + 1'b1;
          default: ;
        endcase
      end

      if (abort || state != READOUT) begin
        issue_cnt  <= '0;
        accept_cnt <= '0;
        rd_pending <= 1'b0;
        skid_valid <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        rd_pending <= issue;
        if (issue) begin
          rd_ptr    <= rd_ptr + 1'b1;
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (pop) accept_cnt <= accept_cnt + 1'b1;
        if (!out_valid || pop) begin
          if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= rd_pending;
            if (rd_pending) skid_data <= ram_q;
          end else if (rd_pending) begin
            out_data  <= ram_q;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (rd_pending) begin
          skid_valid <= 1'b1;
          skid_data  <= ram_q;
        end
      end
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_next;

  always_comb begin
    ts_next = (ts_cnt == '1) ? ts_cnt : ts_cnt + 1'b1;
  end

  // Qualified-cycle count from arm, latched on the trigger that is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt         <= '0;
      trig_timestamp <= '0;
    end else if (!abort) begin
      if (state == IDLE && arm) begin
        ts_cnt         <= '0;
        trig_timestamp <= '0;
      end else if (clk_enable && (state == PRE_FILL || state == WAIT_TRIG)) begin
        ts_cnt <= ts_next;
        if (trig_hit) trig_timestamp <= ts_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hdlverifier_capture_buffer_ctrl.sv
// Self-checking bench for hdlverifier_capture_buffer_ctrl: table-driven
// directed captures, abort/reset sequences and randomized captures, all
// checked against a sample-log reference model.
module tb_hdlverifier_capture_buffer_ctrl;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_enable;
  logic [DW-1:0] data_in;
  logic          trigger;
  logic          arm;
  logic          abort;
  logic [AW-1:0] pretrigger_depth;
  logic          busy;
  logic          capture_done;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0]   trig_timestamp;
`endif

  hdlverifier_capture_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clk_enable(clk_enable),
    .data_in(data_in),
    .trigger(trigger),
    .arm(arm),
    .abort(abort),
    .pretrigger_depth(pretrigger_depth),
    .busy(busy),
    .capture_done(capture_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
`ifdef CAPTURE_TIMESTAMP_EN
    ,.trig_timestamp(trig_timestamp)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 capturing, 2 reading out
  int          mph = 0;
  int          m_pre, nwr, trig_n, acc, wait_cnt;
  bit          trig_done, prev_accept;
  logic [31:0] prev = '0;
  logic [31:0] wlog[$];
  logic [31:0] exp_q[$];
  logic        ov = 1'b0;
  logic [31:0] od = '0;
  logic [31:0] first_seen, last_seen;
`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] m_ts = '0;
  logic [31:0] m_ts_out = '0;
`endif

  typedef struct {
    int          pre;
    bit          alt;
    int          arm_at;
    int          trig_at;
    int          early_at;
    int          rmode;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] exp_ts;
`endif
  } vec_t;

  vec_t tbl[5];
  bit   rpat[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then check
  task automatic tick();
    bit acc_now;
    @(posedge clk);
    acc_now     = ov && out_ready;
    prev_accept = 1'b0;
    if (abort) begin
      mph = 0;
      exp_q.delete();
    end else begin
      case (mph)
        0: if (arm) begin
          m_pre = int'(pretrigger_depth);
          wlog.delete();
          nwr = 0;
          trig_done = 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
          m_ts = '0;
          m_ts_out = '0;
`endif
          mph = 1;
        end
        1: if (clk_enable) begin
          wlog.push_back(prev);
          nwr++;
`ifdef CAPTURE_TIMESTAMP_EN
          if (!trig_done && m_ts != 32'hFFFFFFFF) m_ts++;
`endif
          if (!trig_done && trigger && nwr > m_pre) begin
            trig_done = 1'b1;
            trig_n = nwr;
`ifdef CAPTURE_TIMESTAMP_EN
            m_ts_out = m_ts;
`endif
          end
          if (trig_done && nwr == trig_n + (DEPTH - m_pre) - 1) begin
            exp_q.delete();
            for (int i = wlog.size() - DEPTH; i < wlog.size(); i++) exp_q.push_back(wlog[i]);
            mph = 2;
            acc = 0;
            wait_cnt = 0;
          end
        end
        default: if (acc_now) begin
          if (acc == 0) first_seen = od;
          if (acc == DEPTH - 1) last_seen = od;
          acc++;
          prev_accept = 1'b1;
          if (acc == DEPTH) begin
            mph = 0;
            prev_accept = 1'b0;
          end
        end
      endcase
    end
    if (clk_enable) prev = data_in;
    #1;
    chk("busy", {31'b0, busy}, {31'b0, mph != 0});
    chk("capture_done", {31'b0, capture_done}, {31'b0, mph == 2});
    if (mph != 2) begin
      chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
    end else if (out_valid) begin
      chk("out_data", out_data, exp_q[acc]);
      chk("out_last", {31'b0, out_last}, {31'b0, acc == DEPTH - 1});
    end else begin
      chk("out_last_novalid", {31'b0, out_last}, 32'd0);
      if (acc == 0) begin
        wait_cnt++;
        if (wait_cnt > 2) chk("first_valid_latency", {31'b0, out_valid}, 32'd1);
      end
      if (prev_accept) chk("back_to_back_valid", {31'b0, out_valid}, 32'd1);
    end
`ifdef CAPTURE_TIMESTAMP_EN
    chk("trig_timestamp", trig_timestamp, m_ts_out);
`endif
    ov = out_valid;
    od = out_data;
  endtask

  task automatic idle_inputs();
    clk_enable = 1'b1;
    trigger = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input string nm);
    first_seen = 'x;
    last_seen  = 'x;
    for (int c = 0; c < 300; c++) begin
      clk_enable       = v.alt ? (c % 2 == 0) : 1'b1;
      data_in          = 32'(c);
      arm              = (c == v.arm_at);
      trigger          = (c == v.trig_at) || (c == v.early_at);
      pretrigger_depth = AW'(v.pre);
      out_ready        = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? rpat[c % 4] : 1'($urandom);
      tick();
      if (c > v.arm_at && mph == 0) break;
    end
    idle_inputs();
    chk({nm, "_done_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_first"}, first_seen, v.exp_first);
    chk({nm, "_last"}, last_seen, v.exp_last);
`ifdef CAPTURE_TIMESTAMP_EN
    chk({nm, "_ts"}, trig_timestamp, v.exp_ts);
`endif
  endtask

  initial begin
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[0] = '{pre:4,  alt:0, arm_at:0, trig_at:21, early_at:-1, rmode:0, exp_first:16, exp_last:31
`ifdef CAPTURE_TIMESTAMP_EN
               , exp_ts:21
`endif
              };
    tbl[1] = '{pre:0,  alt:0, arm_at:7, trig_at:8,  early_at:-1, rmode:0, exp_first:7,  exp_last:22
`ifdef CAPTURE_TIMESTAMP_EN
               , exp_ts:1
`endif
              };
    tbl[2] = '{pre:15, alt:0, arm_at:0, trig_at:31, early_at:10, rmode:1, exp_first:15, exp_last:30
`ifdef CAPTURE_TIMESTAMP_EN
               , exp_ts:31
`endif
              };
    tbl[3] = '{pre:15, alt:0, arm_at:0, trig_at:31, early_at:15, rmode:2, exp_first:15, exp_last:30
`ifdef CAPTURE_TIMESTAMP_EN
               , exp_ts:31
`endif
              };
    tbl[4] = '{pre:2,  alt:1, arm_at:0, trig_at:20, early_at:-1, rmode:1, exp_first:14, exp_last:44
`ifdef CAPTURE_TIMESTAMP_EN
               , exp_ts:10
`endif
              };

    reset_n = 1'b0;
    idle_inputs();
    data_in = '0;
    pretrigger_depth = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_capture_done", {31'b0, capture_done}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_last", {31'b0, out_last}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_case(tbl[i], $sformatf("vec%0d", i));

    // Abort while beat 5 is presented, then a fresh capture
    pretrigger_depth = 4'd4;
    for (int c = 0; c < 200; c++) begin
      data_in = 32'(c);
      arm = (c == 0);
      trigger = (c == 21);
      out_ready = 1'b1;
      if (mph == 2 && ov && acc == 4) begin
        abort = 1'b1;
        out_ready = 1'b0;
      end
      tick();
      if (abort) break;
    end
    chk("abort_seen", {31'b0, abort}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_capture_done", {31'b0, capture_done}, 32'd0);
    idle_inputs();
    tick();
    run_case(tbl[0], "after_abort");

    // Asynchronous reset in the middle of a capture
    pretrigger_depth = 4'd4;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", {31'b0, busy}, 32'd0);
    chk("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    mph = 0;
    prev = '0;
    ov = 1'b0;
`ifdef CAPTURE_TIMESTAMP_EN
    m_ts_out = '0;
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Randomized captures: random qualifier, data, triggers, ready, stray arms/aborts
    for (int it = 0; it < 8; it++) begin
      pretrigger_depth = AW'($urandom_range(0, 15));
      for (int c = 0; c < 800; c++) begin
        clk_enable = ($urandom % 4) != 0;
        data_in    = $urandom;
        arm        = (c == 2) || (($urandom % 60) == 0);
        trigger    = ($urandom % 8) == 0;
        out_ready  = 1'($urandom);
        abort      = ($urandom % 400) == 0;
        tick();
        if (c > 2 && mph == 0) break;
      end
      idle_inputs();
      if (mph != 0) begin
        chk("random_timeout_busy", {31'b0, busy}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdlverifier_capture_buffer_ctrl.md
Name: hdlverifier_capture_buffer_ctrl

Overview:
- Consumer side of the 1-bit capture trigger path: arms on host request and records samples into an internal circular RAM.
- On the registered trigger from the capture comparator it freezes a window of pre- and post-trigger samples.
- It then streams the window out oldest-first over a valid/ready interface to the JTAG/Ethernet upload logic.

Parameters:
DATA_WIDTH, 32, width of captured sample word
ADDR_WIDTH, 4, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
clk_enable  input  1  sample qualifier; gates all capture-side activity
data_in  input  DATA_WIDTH  sample stream, same timing as comparator data input
trigger  input  1  registered trigger from comparator (one cycle after causing sample)
arm  input  1  single-cycle capture start request
abort  input  1  returns block to IDLE
pretrigger_depth  input  ADDR_WIDTH  number of samples kept before trigger sample
busy  output  1  high in any state except IDLE
capture_done  output  1  high from window complete until last beat accepted
out_valid  output  1  readout data valid
out_ready  input  1  readout consumer ready
out_data  output  DATA_WIDTH  readout sample
out_last  output  1  marks final (DEPTH-th) beat

Behaviour:
- Reset: state IDLE, all outputs 0, write/read pointers 0.
- Alignment: data_in is delayed one clk_enable-qualified sample internally, so the sample written in the cycle trigger is seen is the sample that caused it.
- Writes occur only on clk_enable=1 cycles in PRE_FILL, WAIT_TRIG and POST. wr_ptr increments mod DEPTH.
- pretrigger_depth is sampled at arm; effective pre = min(value, DEPTH-1); post = DEPTH - pre, including the trigger sample.
- IDLE: on arm, go to PRE_FILL, or to WAIT_TRIG if pre=0. arm is ignored in all other states.
- PRE_FILL: count writes; after pre writes go to WAIT_TRIG. trigger is ignored here.
- WAIT_TRIG: writes continue circularly. On trigger=1 with clk_enable=1: trig_addr = wr_ptr of that write, post counter = 1 (trigger sample counts); go to POST, or straight to READOUT if post=1.
- POST: after post total writes go to READOUT. rd_ptr = (trig_addr - pre) mod DEPTH. Further triggers are ignored.
- READOUT: capture_done=1. Synchronous RAM read with an output register plus a one-entry skid so that:
  - out_valid/out_data stay stable until out_ready.
  - Back-to-back beats sustain 1 per cycle while out_ready=1.
  - First out_valid appears no later than 2 cycles after READOUT entry.
  - Exactly DEPTH beats are sent; out_last=1 on beat DEPTH.
  - After the last beat is accepted: capture_done=0, go to IDLE.
  - clk_enable does not affect readout.
- abort (any state, highest priority): go to IDLE on the next edge, out_valid/capture_done/busy drop that edge, and the in-flight readout is discarded.
- Simultaneous arm+abort: abort wins.
- Simultaneous trigger in PRE_FILL's final write cycle: ignored (trigger is only qualified in WAIT_TRIG).
- Reset asserted mid-capture or mid-readout: immediate return to reset values. RAM contents are don't-care.

Optional Feature:
Macro CAPTURE_TIMESTAMP_EN.
- Defined: adds output trig_timestamp (32 bits), a saturating count of clk_enable cycles from arm to the qualifying trigger.
  - Captured on the trigger; holds until the next arm; reset 0.
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- ADDR_WIDTH=4, ramp data_in=0,1,2… every cycle, pre=4, comparator trigger caused by sample 20 -> readout 16 beats 16..31, out_last on 31, capture_done falls after beat 16.
- pre=0, trigger on first WAIT_TRIG sample 7 -> readout 7..22.
- pre=15, trigger during PRE_FILL ignored; first valid trigger caused by sample 30 -> readout 15..30.
- Readout with out_ready toggling 1,0,0,1 random -> no dropped or duplicated beats, out_data stable while stalled, order matches ramp.
- abort asserted on beat 5 of readout -> out_valid=0 next cycle, busy=0. New arm captures a fresh correct window.
- clk_enable=1 every other cycle, pre=2 -> only qualified samples stored, window contiguous in sample index. With CAPTURE_TIMESTAMP_EN, trig_timestamp equals the number of qualified cycles from arm to trigger.
